state_shift_engine: RTL and testbench

STATE_SHIFT_ENGINE -- requirements
Module: state_shift_engine

---
 rtl/ascon_params.sv | 25 ++
 rtl/shift_step_counter.sv | 31 +++
 rtl/state_shift_engine.sv | 138 +++++++++++++
 tb/tb_state_shift_engine.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_params.sv
// Shared defaults, derived step geometry and FSM encoding for the state shift engine.
package ascon_params;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    localparam int COL_SIZE  = 5;
    localparam int WORD_SIZE = 64;
    localparam int PAR       = 4;
    localparam int D         = 1;
    localparam int SW        = (D + 1) * PAR;
    localparam int SB        = (SW < WORD_SIZE) ? SW : WORD_SIZE;
    localparam int N0        = ceil_div(WORD_SIZE, PAR);
    localparam int N1        = ceil_div(WORD_SIZE, SW);
    localparam int L0        = WORD_SIZE - (N0 - 1) * PAR;
    localparam int L1        = WORD_SIZE - (N1 - 1) * SW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/shift_step_counter.sv
// Step counter for a shift run; flags the final step for the latched mode.
module shift_step_counter #(
    parameter int N0 = 16,
    parameter int N1 = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    input  logic mode,
    output logic last
);

    localparam int NMAX = (N0 > N1) ? N0 : N1;
    localparam int CW   = $clog2(NMAX + 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign last = mode ? (count_q == CW'(N1 - 1)) : (count_q == CW'(N0 - 1));

endmodule

// File: rtl/state_shift_engine.sv
// Multi-word state register with masked parallel load and serial right-shift runs
// of PAR or (D+1)*PAR bits per step, with hold, abort and a one-cycle done pulse.
module state_shift_engine #(
    parameter int  COL_SIZE  = ascon_params::COL_SIZE,
    parameter int  WORD_SIZE = ascon_params::WORD_SIZE,
    parameter int  PAR       = ascon_params::PAR,
    parameter int  D         = ascon_params::D,
    localparam int SW        = (D + 1) * PAR,
    localparam int SB        = (SW < WORD_SIZE) ? SW : WORD_SIZE
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            load_valid,
    input  logic [COL_SIZE-1:0]             load_mask,
    input  logic [COL_SIZE*WORD_SIZE-1:0]   data_in,
    output logic                            load_ready,
    input  logic                            start,
    input  logic                            mode,
    input  logic                            hold,
    input  logic                            abort,
    input  logic [COL_SIZE*SB-1:0]          in_bits,
    output logic [COL_SIZE*SB-1:0]          out_bits,
    output logic [COL_SIZE*WORD_SIZE-1:0]   data_out,
    output logic                            busy,
    output logic                            last_step,
    output logic                            done
);

    import ascon_params::fsm_state_t;
    import ascon_params::ST_IDLE;
    import ascon_params::ST_SHIFT;
    import ascon_params::ST_DONE;
    import ascon_params::ceil_div;

    localparam int N0 = ceil_div(WORD_SIZE, PAR);
    localparam int N1 = ceil_div(WORD_SIZE, SW);
    localparam int L0 = WORD_SIZE - (N0 - 1) * PAR;
    localparam int L1 = WORD_SIZE - (N1 - 1) * SW;
    localparam int KW = $clog2(WORD_SIZE + 1);

    // Non-final widths are clamped so the constants stay in range when w >= WORD_SIZE
    localparam logic [KW-1:0] K0    = KW'((PAR < WORD_SIZE) ? PAR : WORD_SIZE);
    localparam logic [KW-1:0] K1    = KW'((SW < WORD_SIZE) ? SW : WORD_SIZE);
    localparam logic [KW-1:0] KL0   = KW'(L0);
    localparam logic [KW-1:0] KL1   = KW'(L1);
    localparam logic [KW-1:0] KWORD = KW'(WORD_SIZE);

    fsm_state_t state_q, state_d;
    logic [COL_SIZE-1:0][WORD_SIZE-1:0] words_q, words_d, shifted;
    logic mode_q, mode_d;
    logic cnt_clr, cnt_en, cnt_last;
    logic [KW-1:0] k;

    shift_step_counter #(
        .N0 (N0),
        .N1 (N1)
    ) u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .mode    (mode_q),
        .last    (cnt_last)
    );

    always_comb begin
        k = mode_q ? (cnt_last ? KL1 : K1) : (cnt_last ? KL0 : K0);
    end

    // Each word takes the low k serial bits at its top while the old contents slide right by k
    for (genvar i = 0; i < COL_SIZE; i++) begin : g_word
        logic [WORD_SIZE-1:0] in_ext;
        assign in_ext     = WORD_SIZE'(in_bits[i*SB +: SB]);
        assign shifted[i] = (words_q[i] >> k) | (in_ext << (KWORD - k));
        assign out_bits[i*SB +: SB] = words_q[i][SB-1:0];
    end

    // Handshake: a load is accepted on any cycle with load_valid and load_ready both high;
    // start is accepted only when load_ready is high and load_valid is low.
    always_comb begin
        state_d = state_q;
        words_d = words_q;
        mode_d  = mode_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    for (int i = 0; i < COL_SIZE; i++) begin
                        if (load_mask[i]) begin
                            words_d[i] = data_in[i*WORD_SIZE +: WORD_SIZE];
                        end
                    end
                end else if (start) begin
                    mode_d  = mode;
                    cnt_clr = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!hold) begin
                    words_d = shifted;
                    cnt_en  = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            words_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            mode_q  <= mode_d;
        end
    end

    assign data_out   = words_q;
    assign busy       = (state_q == ST_SHIFT);
    assign done       = (state_q == ST_DONE);
    assign last_step  = busy && cnt_last;
    assign load_ready = reset_n && (state_q == ST_IDLE);

endmodule

// File: tb/tb_state_shift_engine.sv
// Directed vector bench for state_shift_engine with COL_SIZE=5, WORD_SIZE=64, PAR=5, D=1.
module tb_state_shift_engine;

    localparam int COLS = 5;
    localparam int WS   = 64;
    localparam int SBW  = 10;
    localparam int NV   = 10;

    logic                 clk;
    logic                 reset_n;
    logic                 load_valid;
    logic [COLS-1:0]      load_mask;
    logic [COLS*WS-1:0]   data_in;
    logic                 load_ready;
    logic                 start;
    logic                 mode;
    logic                 hold;
    logic                 abort;
    logic [COLS*SBW-1:0]  in_bits;
    logic [COLS*SBW-1:0]  out_bits;
    logic [COLS*WS-1:0]   data_out;
    logic                 busy;
    logic                 last_step;
    logic                 done;

    int checks = 0;
    int passed = 0;

    state_shift_engine #(
        .COL_SIZE  (COLS),
        .WORD_SIZE (WS),
        .PAR       (5),
        .D         (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_mask  (load_mask),
        .data_in    (data_in),
        .load_ready (load_ready),
        .start      (start),
        .mode       (mode),
        .hold       (hold),
        .abort      (abort),
        .in_bits    (in_bits),
        .out_bits   (out_bits),
        .data_out   (data_out),
        .busy       (busy),
        .last_step  (last_step),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        mode;
        logic [63:0] init;
        logic [9:0]  in_word;
        int          hold_step;
        int          hold_len;
        int          abort_step;
        logic [9:0]  exp_first;
        int          exp_busy;
        int          exp_nlast;
        int          exp_ndone;
        logic [63:0] exp_final;
    } vec_t;

    vec_t vecs[NV];

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t r);
        int nbusy = 0;
        int nlast = 0;
        int ndone = 0;
        int done_pos = 0;
        int steps = 0;
        int held = 0;
        logic last_end = 1'b0;
        logic [9:0] first_out = '0;
        string tag;
        tag = $sformatf("v%0d", idx);

        @(negedge clk);
        load_valid = 1'b1;
        load_mask  = '1;
        data_in    = {COLS{r.init}};
        @(negedge clk);
        load_valid = 1'b0;
        start      = 1'b1;
        mode       = r.mode;
        in_bits    = {COLS{r.in_word}};
        data_in    = '0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            if (busy) begin
                nbusy++;
                if (nbusy == 1) first_out = out_bits[9:0];
                if (last_step) nlast++;
                last_end = last_step;
            end
            if (done) begin
                ndone++;
                done_pos = c;
            end
            // Loads and starts while busy must be ignored
            load_valid = busy;
            start      = busy;
            hold       = 1'b0;
            abort      = 1'b0;
            if (busy) begin
                if (r.abort_step != 0 && steps == r.abort_step - 1) begin
                    abort = 1'b1;
                end else if (r.hold_len > 0 && steps == r.hold_step - 1 && held < r.hold_len) begin
                    hold = 1'b1;
                    held++;
                end else begin
                    steps++;
                end
            end
            @(negedge clk);
        end
        load_valid = 1'b0;
        start      = 1'b0;
        hold       = 1'b0;
        abort      = 1'b0;

        check({tag, "_busy_cycles"}, 320'(nbusy), 320'(r.exp_busy));
        check({tag, "_last_count"}, 320'(nlast), 320'(r.exp_nlast));
        check({tag, "_last_on_final"}, 320'(last_end), 320'(r.exp_ndone > 0));
        check({tag, "_done_count"}, 320'(ndone), 320'(r.exp_ndone));
        if (r.exp_ndone > 0) check({tag, "_done_pos"}, 320'(done_pos), 320'(r.exp_busy + 1));
        check({tag, "_first_out"}, 320'(first_out), 320'(r.exp_first));
        check({tag, "_final_state"}, data_out, {COLS{r.exp_final}});
        check({tag, "_idle_after"}, 320'(load_ready), 320'(1));
    endtask

    initial begin
        logic [63:0]  exp_w[COLS];
        logic [319:0] exp_v;
        logic [49:0]  exp_ob;
        int ndone;

        vecs[0] = '{1'b0, 64'h0, 10'h3FF, 0, 0, 0, 10'h000, 13, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[1] = '{1'b1, 64'h0123_4567_89AB_CDEF, 10'h000, 0, 0, 0, 10'h1EF, 7, 1, 1, 64'h0};
        vecs[2] = '{1'b1, 64'h0, 10'h155, 0, 0, 0, 10'h000, 7, 1, 1, 64'h5555_5555_5555_5555};
        vecs[3] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 10'h000, 0, 0, 0, 10'h3FF, 13, 1, 1, 64'h0};
        vecs[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 10'h2AA, 0, 0, 0, 10'h3FF, 7, 1, 1, 64'hAAAA_AAAA_AAAA_AAAA};
        vecs[5] = '{1'b0, 64'h0, 10'h3E1, 0, 0, 0, 10'h000, 13, 1, 1, 64'h1084_2108_4210_8421};
        vecs[6] = '{1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 10'h001, 0, 0, 0, 10'h2AA, 7, 1, 1, 64'h1004_0100_4010_0401};
        vecs[7] = '{1'b0, 64'h0, 10'h3FF, 5, 3, 0, 10'h000, 16, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[8] = '{1'b1, 64'h0, 10'h001, 7, 2, 0, 10'h000, 9, 3, 1, 64'h1004_0100_4010_0401};
        vecs[9] = '{1'b0, 64'h0, 10'h3FF, 0, 0, 4, 10'h000, 4, 0, 0, 64'hFFFE_0000_0000_0000};

        reset_n    = 1'b1;
        load_valid = 1'b0;
        load_mask  = '0;
        data_in    = '0;
        start      = 1'b0;
        mode       = 1'b0;
        hold       = 1'b0;
        abort      = 1'b0;
        in_bits    = '0;

        // Power-on reset
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", 320'(busy), 320'(0));
        check("rst_done", 320'(done), 320'(0));
        check("rst_last", 320'(last_step), 320'(0));
        check("rst_ready", 320'(load_ready), 320'(0));
        check("rst_data", data_out, 320'(0));
        check("rst_out_bits", 320'(out_bits), 320'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready_after", 320'(load_ready), 320'(1));

        for (int v = 0; v < NV; v++) begin
            run_vec(v, vecs[v]);
        end

        // Reset in the middle of a run
        @(negedge clk);
        load_valid = 1'b1;
        load_mask  = '1;
        data_in    = '0;
        @(negedge clk);
        load_valid = 1'b0;
        start      = 1'b1;
        mode       = 1'b0;
        in_bits    = {COLS{10'h3FF}};
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("mid_busy_before", 320'(busy), 320'(1));
        reset_n = 1'b0;
        #1;
        check("mid_rst_data", data_out, 320'(0));
        check("mid_rst_busy", 320'(busy), 320'(0));
        check("mid_rst_ready", 320'(load_ready), 320'(0));
        check("mid_rst_out_bits", 320'(out_bits), 320'(0));
        check("mid_rst_last", 320'(last_step), 320'(0));
        repeat (3) begin
            @(negedge clk);
            if (done) ndone++;
        end
        reset_n = 1'b1;
        @(negedge clk);
        if (done) ndone++;
        check("mid_ready_after", 320'(load_ready), 320'(1));
        check("mid_data_after", data_out, 320'(0));
        check("mid_busy_after", 320'(busy), 320'(0));
        check("mid_no_done", 320'(ndone), 320'(0));

        // Masked load, with a start in the same cycle that must be dropped
        for (int i = 0; i < COLS; i++) exp_w[i] = 64'h1111_1111_1111_1111 * 64'(i + 1);
        @(negedge clk);
        load_valid = 1'b1;
        load_mask  = '1;
        for (int i = 0; i < COLS; i++) data_in[i*WS +: WS] = exp_w[i];
        @(negedge clk);
        load_mask = 5'b00100;
        data_in   = {COLS{64'hAAAA_AAAA_AAAA_AAAA}};
        start     = 1'b1;
        mode      = 1'b0;
        exp_w[2]  = 64'hAAAA_AAAA_AAAA_AAAA;
        @(negedge clk);
        load_valid = 1'b0;
        start      = 1'b0;
        for (int i = 0; i < COLS; i++) begin
            exp_v[i*WS +: WS]    = exp_w[i];
            exp_ob[i*SBW +: SBW] = exp_w[i][9:0];
        end
        check("mask_busy", 320'(busy), 320'(0));
        check("mask_data", data_out, exp_v);
        check("mask_out_bits", 320'(out_bits), 320'(exp_ob));
        @(negedge clk);
        check("mask_busy_later", 320'(busy), 320'(0));
        check("mask_ready", 320'(load_ready), 320'(1));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
